// File: rtl/csa_accum_ctrl.sv
// Sequential multi-operand adder: keeps the running total in carry-save form
// (sum S, carry C) and resolves it with a single carry-propagate add per stream.
module csa_accum_ctrl #(
    parameter  int WIDTH   = 4,
    parameter  int OUT_W   = 8,
    parameter  int MAX_OPS = 16,
    localparam int CNT_W   = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_cnt
);

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_OPS - 1);

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   s_q, s_d;
    logic [OUT_W-1:0]   c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [OUT_W-1:0]   res_q;
    logic               res_ovf_q;
    logic [CNT_W-1:0]   res_cnt_q;
    logic               load_out;
    logic               accept;

    logic [OUT_W-1:0]   x_ext;
    logic [OUT_W-1:0]   csa_sum;
    logic [OUT_W-1:0]   csa_maj;
    logic [OUT_W-1:0]   cpa_res;
    logic               cpa_co;

    assign x_ext = OUT_W'(in_data);

    // One full-adder cell per bit: sum stays in place, majority moves up one bit.
    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_csa
            assign csa_sum[gi] = s_q[gi] ^ c_q[gi] ^ x_ext[gi];
            assign csa_maj[gi] = (s_q[gi] & c_q[gi]) | (s_q[gi] & x_ext[gi])
                               | (c_q[gi] & x_ext[gi]);
        end
    endgenerate

    assign {cpa_co, cpa_res} = {1'b0, s_q} + {1'b0, c_q};

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid & in_ready;

    assign out_sum = res_q;
    assign out_ovf = res_ovf_q;
    assign out_cnt = res_cnt_q;

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        load_out = 1'b0;

        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    s_d   = csa_sum;
                    c_d   = {csa_maj[OUT_W-2:0], 1'b0};
                    cnt_d = cnt_q + CNT_W'(1);
                    // A majority bit shifted out of the top is a 2^OUT_W carry lost for good.
                    ovf_d = ovf_q | csa_maj[OUT_W-1];
                    if (in_last || (cnt_q == LAST_CNT)) begin
                        state_d = ST_RESOLVE;
                    end
                end
            end
            ST_RESOLVE: begin
                load_out = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase

        // Abort overrides any handshake and leaves the last published result alone.
        if (clr) begin
            state_d  = ST_ACCUM;
            s_d      = '0;
            c_d      = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            load_out = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACCUM;
            s_q       <= '0;
            c_q       <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
            res_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            if (load_out) begin
                res_q     <= cpa_res;
                res_ovf_q <= ovf_q | cpa_co;
                res_cnt_q <= cnt_q;
            end
        end
    end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Randomised and directed checks of csa_accum_ctrl; two instances (OUT_W=8 and
// OUT_W=5) share one stimulus stream and are compared against an integer-sum model.
module tb_csa_accum_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, out_ovf_a;
    logic [7:0] out_sum_a;
    logic [4:0] out_cnt_a;
    logic       in_ready_b, out_valid_b, out_ovf_b;
    logic [4:0] out_sum_b;
    logic [4:0] out_cnt_b;

    int n_tests = 0;
    int n_fail  = 0;
    int ops_q[$];

    always #5 clk = ~clk;

    csa_accum_ctrl #(.WIDTH(4), .OUT_W(8), .MAX_OPS(16)) dut_a (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sum(out_sum_a), .out_ovf(out_ovf_a), .out_cnt(out_cnt_a)
    );

    csa_accum_ctrl #(.WIDTH(4), .OUT_W(5), .MAX_OPS(16)) dut_b (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sum(out_sum_b), .out_ovf(out_ovf_b), .out_cnt(out_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_ready_valid(input string tag, input logic rdy, input logic vld);
        check({tag, "_in_ready_a"},  32'(in_ready_a),  32'(rdy));
        check({tag, "_in_ready_b"},  32'(in_ready_b),  32'(rdy));
        check({tag, "_out_valid_a"}, 32'(out_valid_a), 32'(vld));
        check({tag, "_out_valid_b"}, 32'(out_valid_b), 32'(vld));
    endtask

    task automatic check_result(input string tag, input int sum, input int cnt);
        check({tag, "_sum_a"}, 32'(out_sum_a), 32'(sum % 256));
        check({tag, "_ovf_a"}, 32'(out_ovf_a), 32'(sum >= 256));
        check({tag, "_cnt_a"}, 32'(out_cnt_a), 32'(cnt));
        check({tag, "_sum_b"}, 32'(out_sum_b), 32'(sum % 32));
        check({tag, "_ovf_b"}, 32'(out_ovf_b), 32'(sum >= 32));
        check({tag, "_cnt_b"}, 32'(out_cnt_b), 32'(cnt));
    endtask

    // Presents one operand (after optional idle bubbles) and returns on the accepting edge.
    task automatic send_op(input int d, input logic last, input int gaps);
        for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 4'($urandom);
            in_last  = 1'($urandom);
        end
        @(negedge clk);
        check("accum_in_ready_a", 32'(in_ready_a), 32'd1);
        in_valid = 1'b1;
        in_data  = 4'(d);
        in_last  = last;
        @(posedge clk);
    endtask

    // Sends ops_q as one stream, checks the resolve latency and the result.
    // consume=0 leaves both DUTs sitting in DONE.
    task automatic run_stream(input string tag, input bit use_last, input int max_gap,
                              input int bp, input bit consume);
        int sum = 0;
        int n   = ops_q.size();
        for (int i = 0; i < n; i++) begin
            sum += ops_q[i];
            send_op(ops_q[i], use_last && (i == n - 1), $urandom_range(0, max_gap));
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_ready_valid({tag, "_resolve"}, 1'b0, 1'b0);
        @(negedge clk);
        check_ready_valid({tag, "_done"}, 1'b0, 1'b1);
        check_result(tag, sum, n);
        $display("[TB] %s: %0d ops, sum=%0d -> a=%0d/%0d b=%0d/%0d cnt=%0d", tag, n, sum,
                 out_sum_a, out_ovf_a, out_sum_b, out_ovf_b, out_cnt_a);
        for (int k = 0; k < bp; k++) begin
            in_valid = 1'($urandom);
            in_data  = 4'($urandom);
            @(negedge clk);
            check_ready_valid({tag, "_hold"}, 1'b0, 1'b1);
            check({tag, "_hold_sum_a"}, 32'(out_sum_a), 32'(sum % 256));
            check({tag, "_hold_sum_b"}, 32'(out_sum_b), 32'(sum % 32));
        end
        in_valid = 1'b0;
        if (consume) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check_ready_valid({tag, "_after"}, 1'b1, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_ready_valid("reset", 1'b1, 1'b0);
        check_result("reset", 0, 0);

        ops_q = '{3, 5, 7};
        run_stream("basic", 1'b1, 0, 0, 1'b1);

        ops_q = {};
        for (int i = 0; i < 16; i++) ops_q.push_back(15);
        run_stream("implicit_last", 1'b0, 0, 0, 1'b1);

        ops_q = '{15, 15, 15};
        run_stream("ovf", 1'b1, 0, 5, 1'b1);

        ops_q = '{1, 2};
        run_stream("after_bp", 1'b1, 0, 0, 1'b1);

        // Abort mid-stream; the operand offered alongside clr must be dropped.
        send_op(9, 1'b0, 0);
        send_op(9, 1'b0, 0);
        @(negedge clk);
        clr = 1'b1; in_valid = 1'b1; in_data = 4'd9; in_last = 1'b1;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check_ready_valid("abort", 1'b1, 1'b0);
        check_result("abort_keeps_prev", 3, 2);
        ops_q = '{4};
        run_stream("post_abort", 1'b1, 0, 0, 1'b0);

        // clr beats out_ready in DONE: no transfer, back to ACCUM, result registers kept.
        clr = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        clr = 1'b0; out_ready = 1'b0;
        check_ready_valid("clr_done", 1'b1, 1'b0);
        check_result("clr_done_keeps", 4, 1);
        ops_q = '{2};
        run_stream("post_clr_done", 1'b1, 0, 0, 1'b1);

        for (int s = 0; s < 25; s++) begin
            int n = $urandom_range(1, 16);
            bit ul = (n < 16) ? 1'b1 : 1'($urandom);
            ops_q = {};
            for (int i = 0; i < n; i++) ops_q.push_back($urandom_range(0, 15));
            run_stream($sformatf("rand%0d", s), ul, 2, $urandom_range(0, 3), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
